mc_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS32 processor variant. Decodes the 6-bit opcode and sequences the shared ALU, memory port, instruction register, PC and register file over several cycles per instruction. Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode by funct. Sits between the instruction register opcode field and all datapath enables/muxes.

---
 rtl/mc_ctrl.sv | 152 +++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM for the MIPS32 datapath: fetch, decode and per-opcode
// sequencing of the shared ALU, memory port, IR, PC and register file.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StAluWb, StBranch, StJump, StAddiEx, StAddiWb
  } state_e;

  state_e state_q, state_d;
  // Opcode is only valid in DECODE, so remember load-vs-store for MEMADR.
  logic   is_store_q, is_store_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRst;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        is_store_d = (opcode == OpSw);
        case (opcode)
          OpR:         state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StAddiEx;
          default:     state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StJump, StAddiWb: state_d = StFetch;
      default:  state_d = StRst;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        illegal   = !(opcode inside {OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi});
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: per-instruction summaries predicted from the
// opcode/wait-state rules and compared whenever the DUT ends an instruction.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal;
  logic [16:0] outs;

  always #5 clk = ~clk;

  assign outs = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_op, alu_src_a,
                 alu_src_b, reg_dst, mem_to_reg, reg_write, instr_done, illegal};

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal)
  );

  // Per-instruction summary: cycle count, event counts, attributes of the final cycle.
  typedef struct {
    int cyc; int ir; int pc_en; int rw; int mw; int req; int iord;
    int funct; int sub; int imm; int ill;
    int done_last; int rd_last; int m2r_last; int pcsrc_last;
  } summ_t;

  summ_t sb_q[$];
  summ_t acc;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    active = 1'b0;

  function automatic void chk(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J ||
           op == OP_ADDI;
  endfunction

  // f = FETCH wait cycles, m = MEMRD/MEMWR wait cycles, z = zero flag during BEQ.
  function automatic summ_t model(logic [5:0] op, int f, int m, bit z);
    summ_t e = '{default: 0};
    e.ir = 1; e.pc_en = 1; e.req = f + 1; e.done_last = 1;
    case (op)
      OP_R:    begin e.cyc = 4 + f; e.rw = 1; e.funct = 1; e.rd_last = 1; end
      OP_LW:   begin
        e.cyc = 5 + f + m; e.rw = 1; e.req += m + 1; e.iord = m + 1; e.imm = 1;
        e.m2r_last = 1;
      end
      OP_SW:   begin
        e.cyc = 4 + f + m; e.mw = m + 1; e.req += m + 1; e.iord = m + 1; e.imm = 1;
      end
      OP_BEQ:  begin e.cyc = 3 + f; e.pc_en += int'(z); e.sub = 1; e.pcsrc_last = 1; end
      OP_J:    begin e.cyc = 3 + f; e.pc_en = 2; e.pcsrc_last = 2; end
      OP_ADDI: begin e.cyc = 4 + f; e.rw = 1; e.imm = 1; end
      default: begin e.cyc = 2 + f; e.ill = 1; e.done_last = 0; end
    endcase
    return e;
  endfunction

  // Monitor: accumulate while an instruction is in flight, compare at its last cycle.
  always @(negedge clk) begin
    summ_t e;
    if (!active || !rst_n) begin
      acc = '{default: 0};
    end else begin
      acc.cyc++;
      acc.ir    += int'(ir_write);
      acc.pc_en += int'(pc_en);
      acc.rw    += int'(reg_write);
      acc.mw    += int'(mem_write);
      acc.req   += int'(mem_req);
      acc.iord  += int'(iord);
      acc.ill   += int'(illegal);
      if (alu_op == 2'b10) acc.funct++;
      if (alu_op == 2'b01) acc.sub++;
      if (alu_src_b == 2'b10) acc.imm++;
      if (instr_done || illegal) begin
        acc.done_last  = int'(instr_done);
        acc.rd_last    = int'(reg_dst);
        acc.m2r_last   = int'(mem_to_reg);
        acc.pcsrc_last = int'(pc_src);
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_end", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("cycles", acc.cyc, e.cyc);
          chk("ir_write_cnt", acc.ir, e.ir);
          chk("pc_en_cnt", acc.pc_en, e.pc_en);
          chk("reg_write_cnt", acc.rw, e.rw);
          chk("mem_write_cnt", acc.mw, e.mw);
          chk("mem_req_cnt", acc.req, e.req);
          chk("iord_cnt", acc.iord, e.iord);
          chk("aluop_funct_cnt", acc.funct, e.funct);
          chk("aluop_sub_cnt", acc.sub, e.sub);
          chk("srcb_imm_cnt", acc.imm, e.imm);
          chk("illegal_cnt", acc.ill, e.ill);
          chk("done_last", acc.done_last, e.done_last);
          chk("reg_dst_last", acc.rd_last, e.rd_last);
          chk("mem_to_reg_last", acc.m2r_last, e.m2r_last);
          chk("pc_src_last", acc.pcsrc_last, e.pcsrc_last);
        end
        acc = '{default: 0};
      end
    end
  end

  task automatic run_instr(logic [5:0] op, int f, int m, bit z);
    summ_t e = model(op, f, m, z);
    bit    is_mem = (op == OP_LW) || (op == OP_SW);
    int    ms = f + 3;
    sb_q.push_back(e);
    for (int i = 0; i < e.cyc; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
      if (i < f) mem_ready = 1'b0;
      else if (i == f) mem_ready = 1'b1;
      else if (is_mem && i >= ms && i < ms + m) mem_ready = 1'b0;
      else if (is_mem && i == ms + m) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      opcode = (i == f + 1) ? op : 6'($urandom);
      zero = (op == OP_BEQ) ? z : 1'($urandom);
      if (i == 0) begin
        @(negedge clk);
        chk("fetch_mem_req", int'(mem_req), 1);
        chk("fetch_alu_src_b", int'(alu_src_b), 1);
        chk("fetch_pc_en_gate", int'(pc_en), (f > 0) ? 0 : 1);
      end
    end
  endtask

  logic [5:0] ops [6];

  initial begin
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // Reset held for 3 edges, then one RST cycle with everything low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("outs_in_reset", int'(outs), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cycle_outs", int'(outs), 0);

    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 2, 2, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);

    // Abort a store while MEMWR is waiting on memory.
    @(posedge clk); #1;
    active = 1'b0; opcode = OP_SW; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    opcode = 6'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_memwr_write", int'(mem_write), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_memwr_still", int'(mem_write), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rst_outs", int'(outs), 0);

    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 7) < 6) begin
        op = ops[$urandom_range(0, 5)];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    @(posedge clk); #1;
    active = 1'b0;
    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
